// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor: snoops the fetch bus, detects a halt pattern, drains to end_pc, flags done/timeout.
// Optional HALT_ECALL_EN: ecall/ebreak words also trigger an immediate halt.
module sim_halt_monitor #(
  parameter int ADDR_WIDTH       = 32,
  parameter int CNT_WIDTH        = 32,
  parameter int MAX_CYCLES       = 1000,
  parameter int DRAIN_OFFSET     = 20,
  parameter int ZERO_RUN         = 1,
  parameter int DRAIN_MAX_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  inst_valid,
  input  logic [31:0]           inst_in,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  done,
  output logic                  timeout,
  output logic                  drain_forced,
  output logic [ADDR_WIDTH-1:0] halt_pc,
  output logic [ADDR_WIDTH-1:0] end_pc,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  inst_cnt,
  output logic [2:0]            state
);
  localparam int ZW = $clog2(ZERO_RUN + 1);
  localparam int DW = $clog2(DRAIN_MAX_CYCLES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, DRAIN = 3'd2, DONE = 3'd3, TMO = 3'd4} state_t;
  state_t                state_q, state_d;
  logic                  drain_forced_q, drain_forced_d;
  logic [ADDR_WIDTH-1:0] halt_pc_q, halt_pc_d, end_pc_q, end_pc_d;
  logic [CNT_WIDTH-1:0]  cycle_cnt_q, cycle_cnt_d, inst_cnt_q, inst_cnt_d;
  logic [ZW-1:0]         zero_run_q, zero_run_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic                  is_zero, is_ecall, halt, running;
`ifdef HALT_ECALL_EN
  assign is_ecall = inst_in == 32'h0000_0073 || inst_in == 32'h0010_0073;
`else
  assign is_ecall = 1'b0;
`endif
  assign is_zero = inst_in == 32'h0;
  assign halt    = (is_zero && 32'(zero_run_q) >= ZERO_RUN - 1) || is_ecall;
  assign running = en && (state_q == RUN || state_q == DRAIN || (state_q == IDLE && inst_valid));
  always_comb begin
    state_d        = state_q;
    drain_forced_d = drain_forced_q;
    halt_pc_d      = halt_pc_q;
    end_pc_d       = end_pc_q;
    cycle_cnt_d    = cycle_cnt_q;
    inst_cnt_d     = inst_cnt_q;
    zero_run_d     = zero_run_q;
    drain_d        = drain_q;
    if (running) begin
      cycle_cnt_d = &cycle_cnt_q ? cycle_cnt_q : cycle_cnt_q + 1'b1;
      if (inst_valid) inst_cnt_d = &inst_cnt_q ? inst_cnt_q : inst_cnt_q + 1'b1;
      if (state_q != DRAIN) begin
        state_d = RUN;
        if (inst_valid) begin
          zero_run_d = !is_zero ? '0 : 32'(zero_run_q) >= ZERO_RUN ? zero_run_q : zero_run_q + 1'b1;
          if (halt) begin
            halt_pc_d = inst_addr;
            end_pc_d  = inst_addr + ADDR_WIDTH'(DRAIN_OFFSET);
            drain_d   = '0;
            state_d   = DRAIN;
          end
        end
      end else if (inst_valid && inst_addr == end_pc_q) begin
        state_d = DONE;
      end else if (32'(drain_q) == DRAIN_MAX_CYCLES - 1) begin
        state_d        = DONE;
        drain_forced_d = 1'b1;
      end else begin
        drain_d = drain_q + 1'b1;
      end
      // completion on the budget's last cycle takes priority over timeout
      if (cycle_cnt_q == CNT_WIDTH'(MAX_CYCLES - 1) && state_d != DONE) state_d = TMO;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      drain_forced_q <= 1'b0;
      halt_pc_q      <= '0;
      end_pc_q       <= '0;
      cycle_cnt_q    <= '0;
      inst_cnt_q     <= '0;
      zero_run_q     <= '0;
      drain_q        <= '0;
    end else begin
      state_q        <= state_d;
      drain_forced_q <= drain_forced_d;
      halt_pc_q      <= halt_pc_d;
      end_pc_q       <= end_pc_d;
      cycle_cnt_q    <= cycle_cnt_d;
      inst_cnt_q     <= inst_cnt_d;
      zero_run_q     <= zero_run_d;
      drain_q        <= drain_d;
    end
  end
  assign done         = state_q == DONE;
  assign timeout      = state_q == TMO;
  assign drain_forced = drain_forced_q;
  assign halt_pc      = halt_pc_q;
  assign end_pc       = end_pc_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign inst_cnt     = inst_cnt_q;
  assign state        = state_q;
endmodule

// File: tb/tb_sim_halt_monitor.sv
// tb_sim_halt_monitor: directed + random checks of two monitors (ZERO_RUN=1 and 2) against a reference model.
module tb_sim_halt_monitor;
  logic clk = 0, rstn = 0, en = 0, inst_valid = 0;
  logic [31:0] inst_in = 0, inst_addr = 0;
  logic [1:0]  done, timeout, dforced;
  logic [31:0] hpc_o[2], epc_o[2], cyc_o[2], ic_o[2];
  logic [2:0]  st_o[2];
  int checks = 0, errors = 0;
  int ph[2], zr[2], dc[2];
  longint cyc[2], ic[2];
  logic [31:0] hpc[2], epc[2];
  bit fr[2];
  int zrun[2] = '{1, 2};

  always #5 clk = ~clk;

  sim_halt_monitor dut (.clk(clk), .rstn(rstn), .en(en), .inst_valid(inst_valid), .inst_in(inst_in),
    .inst_addr(inst_addr), .done(done[0]), .timeout(timeout[0]), .drain_forced(dforced[0]), .halt_pc(hpc_o[0]),
    .end_pc(epc_o[0]), .cycle_cnt(cyc_o[0]), .inst_cnt(ic_o[0]), .state(st_o[0]));
  sim_halt_monitor #(.ZERO_RUN(2)) dut2 (.clk(clk), .rstn(rstn), .en(en), .inst_valid(inst_valid), .inst_in(inst_in),
    .inst_addr(inst_addr), .done(done[1]), .timeout(timeout[1]), .drain_forced(dforced[1]), .halt_pc(hpc_o[1]),
    .end_pc(epc_o[1]), .cycle_cnt(cyc_o[1]), .inst_cnt(ic_o[1]), .state(st_o[1]));

  function automatic bit is_ecall(logic [31:0] i);
`ifdef HALT_ECALL_EN
    return i == 32'h0000_0073 || i == 32'h0010_0073;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] nz();
    return ($urandom & 32'hFFFF_FF00) | 32'h13;
  endfunction

  function automatic void model(int k);
    int nxt;
    bit last;
    if (!rstn) begin
      ph[k] = 0; zr[k] = 0; dc[k] = 0; cyc[k] = 0; ic[k] = 0; hpc[k] = 0; epc[k] = 0; fr[k] = 0;
      return;
    end
    if (!en || ph[k] >= 3 || (ph[k] == 0 && !inst_valid)) return;
    last = cyc[k] == 999;
    cyc[k] = cyc[k] + 1;
    if (inst_valid) ic[k] = ic[k] + 1;
    nxt = ph[k] == 0 ? 1 : ph[k];
    if (ph[k] <= 1) begin
      if (inst_valid) begin
        if ((inst_in == 0 && zr[k] + 1 >= zrun[k]) || is_ecall(inst_in)) begin
          hpc[k] = inst_addr;
          epc[k] = 32'((64'(inst_addr) + 20) % 64'h1_0000_0000);
          dc[k] = 0;
          nxt = 2;
        end
        zr[k] = inst_in == 0 ? zr[k] + 1 : 0;
      end
    end else if (inst_valid && inst_addr == epc[k]) nxt = 3;
    else if (dc[k] == 63) begin nxt = 3; fr[k] = 1; end
    else dc[k] = dc[k] + 1;
    if (last && nxt != 3) nxt = 4;
    ph[k] = nxt;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int k);
    chk($sformatf("state%0d", k), 64'(st_o[k]), 64'(ph[k]));
    chk($sformatf("done%0d", k), 64'(done[k]), 64'(ph[k] == 3));
    chk($sformatf("timeout%0d", k), 64'(timeout[k]), 64'(ph[k] == 4));
    chk($sformatf("forced%0d", k), 64'(dforced[k]), 64'(fr[k]));
    chk($sformatf("halt_pc%0d", k), 64'(hpc_o[k]), 64'(hpc[k]));
    chk($sformatf("end_pc%0d", k), 64'(epc_o[k]), 64'(epc[k]));
    chk($sformatf("cycle_cnt%0d", k), 64'(cyc_o[k]), 64'(cyc[k]));
    chk($sformatf("inst_cnt%0d", k), 64'(ic_o[k]), 64'(ic[k]));
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic [31:0] i, input logic [31:0] a);
    rstn = r; en = e; inst_valid = v; inst_in = i; inst_addr = a;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    check_all(0);
    check_all(1);
  endtask

  initial begin
    // reset state
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("rst_state", 64'(st_o[0]), 0);
    // basic halt at 0x0C with drain to 0x20
    for (int a = 0; a <= 32'h20; a += 4) step(1, 1, 1, a == 32'h0C ? 32'h0 : nz(), 32'(a));
    chk("t2_halt_pc", 64'(hpc_o[0]), 64'h0C);
    chk("t2_end_pc", 64'(epc_o[0]), 64'h20);
    chk("t2_done", 64'(done[0]), 1);
    chk("t2_inst_cnt", 64'(ic_o[0]), 9);
    for (int n = 0; n < 5; n++) step(1, 1, 1, 0, 32'h0C);
    chk("t2_frozen", 64'(ic_o[0]), 9);
    // reset mid-DRAIN
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, nz(), 0);
    step(1, 1, 1, 0, 4);
    step(1, 1, 0, 0, 0);
    chk("t1_in_drain", 64'(st_o[0]), 2);
    step(0, 1, 1, 0, 8);
    chk("t1_state", 64'(st_o[0]), 0);
    chk("t1_halt_pc", 64'(hpc_o[0]), 0);
    // ZERO_RUN=2 needs two consecutive zeros
    step(1, 1, 1, 0, 32'h10);
    step(1, 1, 1, nz(), 32'h14);
    step(1, 1, 1, 0, 32'h18);
    step(1, 1, 1, 0, 32'h1C);
    chk("t3_halt_pc_zr2", 64'(hpc_o[1]), 64'h1C);
    chk("t3_halt_pc_zr1", 64'(hpc_o[0]), 64'h10);
    step(1, 1, 1, nz(), 32'h20);
    step(1, 1, 1, nz(), 32'h24);
    step(1, 0, 1, nz(), 32'h30);
    chk("t3_en_freeze", 64'(done[1]), 0);
    step(1, 1, 1, nz(), 32'h30);
    chk("t3_done_zr2", 64'(done[1]), 1);
    // wrapped end_pc, then forced done after 64 drain cycles
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, nz(), 32'hFFFF_FFEC);
    step(1, 1, 1, 0, 32'hFFFF_FFF0);
    chk("t5_end_pc_wrap", 64'(epc_o[0]), 64'h4);
    for (int n = 0; n < 63; n++) step(1, 1, 1'($urandom), nz(), 32'h100 + 4 * $urandom_range(0, 50));
    chk("t5_not_yet", 64'(done[0]), 0);
    step(1, 1, 1, nz(), 32'h180);
    chk("t5_done", 64'(done[0]), 1);
    chk("t5_forced", 64'(dforced[0]), 1);
    // ecall at 0x40
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0073, 32'h40);
`ifdef HALT_ECALL_EN
    chk("t6_ecall_halt", 64'(hpc_o[0]), 64'h40);
`else
    chk("t6_ecall_run", 64'(st_o[0]), 1);
`endif
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [31:0] w;
      r = $urandom_range(0, 99);
      w = r < 15 ? 32'h0 : r < 18 ? 32'h0000_0073 : r < 20 ? 32'h0010_0073 : nz();
      step(1'($urandom_range(0, 99) >= 2), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7), w,
           4 * $urandom_range(0, 15));
    end
    // infinite loop of nonzero instructions times out
    step(0, 1, 0, 0, 0);
    for (int n = 0; n < 1005; n++) step(1, 1, 1, nz(), 32'h200);
    chk("t4_timeout", 64'(timeout[0]), 1);
    chk("t4_cycle_cnt", 64'(cyc_o[0]), 1000);
    chk("t4_done", 64'(done[0]), 0);
    // match on the final budget cycle: done wins over timeout
    step(0, 1, 0, 0, 0);
    for (int n = 0; n < 980; n++) step(1, 1, 1, nz(), 32'h200);
    step(1, 1, 1, 0, 32'h100);
    for (int n = 981; n < 999; n++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, nz(), 32'h114);
    chk("tie_done", 64'(done[0]), 1);
    chk("tie_timeout", 64'(timeout[0]), 0);
    chk("tie_other_tmo", 64'(timeout[1]), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
